iic_slave_regif: RTL

- I2C target (responder) for on-board register access. It is the counterpart of the team's I2C master driver, which uses 2-byte register addresses and 1-byte data.
- Used by bench models and by the FPGA-side configuration register bank, so an external master can write and read 16-bit-addressed 8-bit registers.
- Oversamples SCL/SDA on the system clock and drives SDA open-drain.
- Presents a simple single-cycle register bus to the local register file.

---
 rtl/iic_pkg.sv | 30 +++
 rtl/iic_line_cond.sv | 70 +++++++
 rtl/iic_slave_regif.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iic_pkg.sv
// Shared types and constants for the I2C register-access target.
package iic_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_DEV_ADDR = 4'd1,
        ST_DEV_ACK  = 4'd2,
        ST_ADDR_HI  = 4'd3,
        ST_ACK_HI   = 4'd4,
        ST_ADDR_LO  = 4'd5,
        ST_ACK_LO   = 4'd6,
        ST_WR_DATA  = 4'd7,
        ST_WR_ACK   = 4'd8,
        ST_RD_DATA  = 4'd9,
        ST_RD_ACK   = 4'd10
    } iic_state_e;

    localparam logic IIC_ACK  = 1'b0;
    localparam logic IIC_NACK = 1'b1;

    // Sub-phase inside an ACK bit: waiting for the first SCL fall, ACK held, master ACK seen
    localparam logic [1:0] PH_WAIT = 2'd0;
    localparam logic [1:0] PH_HELD = 2'd1;
    localparam logic [1:0] PH_MACK = 2'd2;

    function automatic logic [15:0] addr_inc(input logic [15:0] a);
        return a + 16'd1;
    endfunction

endpackage

// File: rtl/iic_line_cond.sv
// Conditions one raw I2C line: 2-flop synchroniser, optional glitch filter
// (IIC_SLAVE_GLITCH_FILTER_EN), then rise/fall detection on the clean level.
module iic_line_cond #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rstn,
    input  logic line,
    output logic level,
    output logic rise,
    output logic fall
);

`ifdef IIC_SLAVE_GLITCH_FILTER_EN
    localparam bit FILT_ON = 1'b1;
`else
    localparam bit FILT_ON = 1'b0;
`endif

    logic [1:0] sync_r;
    logic       prev_r;

    // Two-stage synchroniser; idles high like the bus
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], line};
        end
    end

    generate
        if (FILT_ON && (FILT_LEN > 1)) begin : g_filt
            localparam int CW = $clog2(FILT_LEN);
            logic [CW-1:0] cnt_r;
            logic          filt_r;

            // Level follows only after FILT_LEN consecutive samples of the new value
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    cnt_r  <= '0;
                    filt_r <= 1'b1;
                end else if (sync_r[1] == filt_r) begin
                    cnt_r <= '0;
                end else if (cnt_r == CW'(FILT_LEN - 1)) begin
                    cnt_r  <= '0;
                    filt_r <= sync_r[1];
                end else begin
                    cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            assign level = filt_r;
        end else begin : g_nofilt
            assign level = sync_r[1];
        end
    endgenerate

    // Previous clean level for edge detection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev_r <= 1'b1;
        end else begin
            prev_r <= level;
        end
    end

    assign rise = level & ~prev_r;
    assign fall = ~level & prev_r;

endmodule

// File: rtl/iic_slave_regif.sv
// I2C target giving an external master access to 16-bit-addressed 8-bit registers.
// Glitch filtering on SCL/SDA is enabled by IIC_SLAVE_GLITCH_FILTER_EN.
module iic_slave_regif
    import iic_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h59,
    parameter int         FILT_LEN = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_out_en,
    output logic [15:0] reg_addr,
    output logic        reg_wr,
    output logic [7:0]  reg_wdata,
    output logic        reg_rd,
    input  logic [7:0]  reg_rdata,
    output logic        busy,
    output logic        addr_hit
);

    logic scl_s, scl_rise_s, scl_fall_s;
    logic sda_s, sda_rise_s, sda_fall_s;
    logic start_s, stop_s;
    logic [7:0] byte_s;

    iic_state_e state_r, state_n;
    logic [2:0]  bit_cnt_r, bit_cnt_n;
    logic [7:0]  shift_r, shift_n;
    logic [1:0]  phase_r, phase_n;
    logic        rw_r, rw_n;
    logic [15:0] addr_r, addr_n;
    logic [7:0]  wdata_r, wdata_n;
    logic        oe_r, oe_n;
    logic        busy_r, busy_n;
    logic        hit_r, hit_n;
    logic        wr_r, wr_n;
    logic        rd_r, rd_n;
    logic        rd_lat_r, rd_lat_n;
    logic        drv_r, drv_n;
    logic        inc_r, inc_n;
    logic        stop_r, stop_n;

    iic_line_cond #(.FILT_LEN(FILT_LEN)) u_scl (
        .clk(clk), .rstn(rstn), .line(scl_in),
        .level(scl_s), .rise(scl_rise_s), .fall(scl_fall_s)
    );

    iic_line_cond #(.FILT_LEN(FILT_LEN)) u_sda (
        .clk(clk), .rstn(rstn), .line(sda_in),
        .level(sda_s), .rise(sda_rise_s), .fall(sda_fall_s)
    );

    assign start_s = sda_fall_s & scl_s;
    assign stop_s  = sda_rise_s & scl_s;
    assign byte_s  = {shift_r[6:0], sda_s};

    // Protocol state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state and datapath decisions; bus conditions win over bit sampling
    always_comb begin
        state_n   = state_r;
        bit_cnt_n = bit_cnt_r;
        shift_n   = shift_r;
        phase_n   = phase_r;
        rw_n      = rw_r;
        addr_n    = addr_r;
        wdata_n   = wdata_r;
        oe_n      = oe_r;
        busy_n    = busy_r;
        hit_n     = 1'b0;
        wr_n      = 1'b0;
        rd_n      = 1'b0;
        rd_lat_n  = 1'b0;
        drv_n     = 1'b0;
        inc_n     = 1'b0;
        stop_n    = 1'b0;

        if (inc_r) begin
            addr_n = addr_inc(addr_r);
        end else begin
            addr_n = addr_r;
        end
        if (stop_r) begin
            busy_n = 1'b0;
        end else begin
            busy_n = busy_r;
        end

        if (start_s) begin
            state_n   = ST_DEV_ADDR;
            bit_cnt_n = 3'd0;
            phase_n   = PH_WAIT;
            oe_n      = 1'b0;
            busy_n    = 1'b1;
        end else if (stop_s) begin
            state_n = ST_IDLE;
            phase_n = PH_WAIT;
            oe_n    = 1'b0;
            stop_n  = 1'b1;
        end else begin
            // Read pipeline: latch register data, then present its MSB one clk later
            if (rd_lat_r) begin
                shift_n = reg_rdata;
                drv_n   = 1'b1;
                inc_n   = 1'b1;
            end else begin
                drv_n = 1'b0;
            end
            if (drv_r) begin
                oe_n = ~shift_r[7];
            end else begin
                oe_n = oe_r;
            end

            case (state_r)
                ST_DEV_ADDR, ST_ADDR_HI, ST_ADDR_LO, ST_WR_DATA: begin
                    if (scl_rise_s) begin
                        shift_n   = byte_s;
                        bit_cnt_n = bit_cnt_r + 3'd1;
                        phase_n   = PH_WAIT;
                        if (bit_cnt_r == 3'd7) begin
                            case (state_r)
                                ST_DEV_ADDR: begin
                                    if (byte_s[7:1] == DEV_ADDR) begin
                                        hit_n   = 1'b1;
                                        rw_n    = byte_s[0];
                                        state_n = ST_DEV_ACK;
                                    end else begin
                                        state_n = ST_IDLE;
                                        busy_n  = 1'b0;
                                    end
                                end
                                ST_ADDR_HI: begin
                                    addr_n[15:8] = byte_s;
                                    state_n      = ST_ACK_HI;
                                end
                                ST_ADDR_LO: begin
                                    addr_n[7:0] = byte_s;
                                    state_n     = ST_ACK_LO;
                                end
                                ST_WR_DATA: begin
                                    wdata_n = byte_s;
                                    wr_n    = 1'b1;
                                    inc_n   = 1'b1;
                                    state_n = ST_WR_ACK;
                                end
                                default: state_n = ST_IDLE;
                            endcase
                        end else begin
                            state_n = state_r;
                        end
                    end else begin
                        shift_n = shift_n;
                    end
                end
                ST_DEV_ACK, ST_ACK_HI, ST_ACK_LO, ST_WR_ACK: begin
                    if (scl_fall_s && (phase_r == PH_WAIT)) begin
                        oe_n    = 1'b1;
                        phase_n = PH_HELD;
                    end else if (scl_fall_s) begin
                        oe_n      = 1'b0;
                        phase_n   = PH_WAIT;
                        bit_cnt_n = 3'd0;
                        case (state_r)
                            ST_DEV_ACK: begin
                                if (rw_r) begin
                                    state_n  = ST_RD_DATA;
                                    rd_n     = 1'b1;
                                    rd_lat_n = 1'b1;
                                end else begin
                                    state_n = ST_ADDR_HI;
                                end
                            end
                            ST_ACK_HI: state_n = ST_ADDR_LO;
                            default:   state_n = ST_WR_DATA;
                        endcase
                    end else begin
                        phase_n = phase_r;
                    end
                end
                ST_RD_DATA: begin
                    if (scl_rise_s) begin
                        bit_cnt_n = bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            state_n = ST_RD_ACK;
                            phase_n = PH_WAIT;
                        end else begin
                            state_n = ST_RD_DATA;
                        end
                    end else if (scl_fall_s) begin
                        shift_n = {shift_r[6:0], 1'b0};
                        oe_n    = ~shift_r[6];
                    end else begin
                        shift_n = shift_n;
                    end
                end
                ST_RD_ACK: begin
                    // Release SDA, sample the master's ACK, then fetch the next byte
                    if (scl_fall_s && (phase_r == PH_WAIT)) begin
                        oe_n    = 1'b0;
                        phase_n = PH_HELD;
                    end else if (scl_rise_s && (phase_r == PH_HELD)) begin
                        if (sda_s == IIC_NACK) begin
                            state_n = ST_IDLE;
                            busy_n  = 1'b0;
                            phase_n = PH_WAIT;
                        end else begin
                            phase_n = PH_MACK;
                        end
                    end else if (scl_fall_s && (phase_r == PH_MACK)) begin
                        state_n   = ST_RD_DATA;
                        phase_n   = PH_WAIT;
                        bit_cnt_n = 3'd0;
                        rd_n      = 1'b1;
                        rd_lat_n  = 1'b1;
                    end else begin
                        phase_n = phase_r;
                    end
                end
                ST_IDLE: state_n = ST_IDLE;
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
            phase_r   <= PH_WAIT;
            rw_r      <= 1'b0;
            addr_r    <= 16'h0000;
            wdata_r   <= 8'h00;
            oe_r      <= 1'b0;
            busy_r    <= 1'b0;
            hit_r     <= 1'b0;
            wr_r      <= 1'b0;
            rd_r      <= 1'b0;
            rd_lat_r  <= 1'b0;
            drv_r     <= 1'b0;
            inc_r     <= 1'b0;
            stop_r    <= 1'b0;
        end else begin
            bit_cnt_r <= bit_cnt_n;
            shift_r   <= shift_n;
            phase_r   <= phase_n;
            rw_r      <= rw_n;
            addr_r    <= addr_n;
            wdata_r   <= wdata_n;
            oe_r      <= oe_n;
            busy_r    <= busy_n;
            hit_r     <= hit_n;
            wr_r      <= wr_n;
            rd_r      <= rd_n;
            rd_lat_r  <= rd_lat_n;
            drv_r     <= drv_n;
            inc_r     <= inc_n;
            stop_r    <= stop_n;
        end
    end

    assign sda_out_en = oe_r;
    assign reg_addr   = addr_r;
    assign reg_wr     = wr_r;
    assign reg_wdata  = wdata_r;
    assign reg_rd     = rd_r;
    assign busy       = busy_r;
    assign addr_hit   = hit_r;

endmodule
